// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding selects, stage enables, flushes and memory-wait hold for a 5-stage RV32I pipeline
module hazard_fwd_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic              id_use1_i,
  input  logic              id_use2_i,
  input  logic [RA_W-1:0]   ex_rs1_i,
  input  logic [RA_W-1:0]   ex_rs2_i,
  input  logic [RA_W-1:0]   ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_is_load_i,
  input  logic              ex_br_taken_i,
  input  logic [RA_W-1:0]   mem_rd_i,
  input  logic [RA_W-1:0]   mem_rs2_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_is_load_i,
  input  logic              mem_is_store_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic              wb_regwrite_i,
  input  logic              imem_req_i,
  input  logic              dmem_req_i,
  input  logic              imem_resp_i,
  input  logic              dmem_resp_i,
  output logic [1:0]        fwd1_sel_o,
  output logic [1:0]        fwd2_sel_o,
  output logic              mem_fwd2_sel_o,
  output logic              pc_load_o,
  output logic              ifid_load_o,
  output logic              idex_load_o,
  output logic              exmem_load_o,
  output logic              memwb_load_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              imem_req_ok_o,
  output logic              dmem_req_ok_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t           state_q, state_d;
  logic             i_done_q, i_done_d, d_done_q, d_done_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             i_ok, d_ok, go, lu, bubble, br_flush;

  // Selects one operand source; EX/MEM wins over MEM/WB and x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (rs != '0 && mem_regwrite_i && mem_rd_i == rs) return mem_is_load_i ? 2'b11 : 2'b01;
    if (rs != '0 && wb_regwrite_i && wb_rd_i == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Hazard decisions; done flags only count while the pipeline is being held
  always_comb begin
    i_ok     = !imem_req_i | imem_resp_i | (i_done_q & state_q == MEM_WAIT);
    d_ok     = !dmem_req_i | dmem_resp_i | (d_done_q & state_q == MEM_WAIT);
    go       = i_ok & d_ok;
    lu       = ex_is_load_i & ex_regwrite_i & ex_rd_i != '0 &
               ((id_use1_i & id_rs1_i == ex_rd_i) | (id_use2_i & id_rs2_i == ex_rd_i));
    br_flush = go & ex_br_taken_i;
    bubble   = go & lu & !ex_br_taken_i;
    state_d  = go ? RUN : MEM_WAIT;
    i_done_d = go ? 1'b0 : i_done_q | (imem_req_i & imem_resp_i);
    d_done_d = go ? 1'b0 : d_done_q | (dmem_req_i & dmem_resp_i);
    stall_d  = (!go | bubble) && stall_q != '1 ? stall_q + CNT_W'(1) : stall_q;
    flush_d  = br_flush && flush_q != '1 ? flush_q + CNT_W'(1) : flush_q;
  end

  // Output drive; held at reset values while rst_n is low so reset takes effect immediately
  always_comb begin
    fwd1_sel_o     = rst_n ? fwd_sel(ex_rs1_i) : 2'b00;
    fwd2_sel_o     = rst_n ? fwd_sel(ex_rs2_i) : 2'b00;
    mem_fwd2_sel_o = rst_n & mem_is_store_i & wb_regwrite_i & wb_rd_i == mem_rs2_i & mem_rs2_i != '0;
    pc_load_o      = !rst_n | (go & !bubble);
    ifid_load_o    = !rst_n | (go & !bubble);
    idex_load_o    = !rst_n | go;
    exmem_load_o   = !rst_n | go;
    memwb_load_o   = !rst_n | go;
    ifid_flush_o   = rst_n & br_flush;
    idex_flush_o   = rst_n & (br_flush | bubble);
    imem_req_ok_o  = !i_done_q;
    dmem_req_ok_o  = !d_done_q;
    stall_cnt_o    = stall_q;
    flush_cnt_o    = flush_q;
  end

  // State, served-request flags and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end
endmodule
